// File: rtl/edc_scrubber.sv
// edc_scrubber: background SEC-DED scrubber for the cache data array and its 7-bit parity shadow.
module edc_scrubber #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              grant,
    output logic              req,
    output logic [ADDR_W-1:0] arr_addr,
    input  logic [31:0]       arr_data,
    input  logic [6:0]        arr_parity,
    output logic              arr_we,
    output logic [31:0]       arr_wdata,
    output logic [6:0]        arr_wparity,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  ce_count,
    output logic [CNT_W-1:0]  ue_count,
    output logic              ue_flag,
    output logic [ADDR_W-1:0] ue_addr
);
    typedef enum logic [2:0] {IDLE, READ, CHECK, FIX, NEXT, DONE} state_t;
    state_t state;
    logic [31:0] d_q, d_fix;
    logic [6:0] p_q, p_new;
    logic [5:0] syn, p_fix;
    logic ovr, ce, ue, ce_bump;

    // Data bits sit at the non-power-of-two positions 3..38, in ascending order.
    function automatic logic [5:0] enc(input logic [31:0] d);
        logic [5:0] p;
        logic [4:0] j;
        p = '0;
        j = '0;
        for (int pos = 3; pos < 39; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                p = d[j] ? p ^ pos[5:0] : p;
                j = j + 5'd1;
            end
        end
        return p;
    endfunction

    function automatic logic [31:0] flip(input logic [31:0] d, input logic [5:0] s);
        logic [31:0] r;
        logic [4:0] j;
        r = d;
        j = '0;
        for (int pos = 3; pos < 39; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                r[j] = r[j] ^ (s == pos[5:0]);
                j = j + 5'd1;
            end
        end
        return r;
    endfunction

    assign syn   = enc(d_q) ^ p_q[5:0];
    assign ovr   = ^{d_q, p_q};
    assign ce    = ovr && syn <= 6'd38;
    assign ue    = !ce && (ovr || syn != '0);
    assign d_fix = flip(d_q, syn);
    assign p_fix = enc(d_fix);
    assign p_new = {^{d_fix, p_fix}, p_fix};
    // The write is gated by grant in the same cycle so a revoked grant never writes.
    assign arr_we = state == FIX && grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            arr_addr    <= '0;
            arr_wdata   <= '0;
            arr_wparity <= '0;
            ce_count    <= '0;
            ue_count    <= '0;
            ue_flag     <= 1'b0;
            ue_addr     <= '0;
            d_q         <= '0;
            p_q         <= '0;
            ce_bump     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ce_count <= '0;
                    ue_count <= '0;
                    ue_flag  <= 1'b0;
                    ue_addr  <= '0;
                    arr_addr <= '0;
                    busy     <= 1'b1;
                    req      <= 1'b1;
                    state    <= READ;
                end
                READ: if (grant) begin
                    d_q   <= arr_data;
                    p_q   <= arr_parity;
                    state <= CHECK;
                end
                CHECK: begin
                    if (!grant) state <= READ;
                    else if (ce) begin
                        ce_count    <= ce_count + CNT_W'(!(&ce_count));
                        ce_bump     <= !(&ce_count);
                        arr_wdata   <= d_fix;
                        arr_wparity <= p_new;
                        state       <= FIX;
                    end else begin
                        if (ue) begin
                            ue_count <= ue_count + CNT_W'(!(&ue_count));
                            ue_flag  <= 1'b1;
                            ue_addr  <= ue_flag ? ue_addr : arr_addr;
                        end
                        state <= NEXT;
                    end
                end
                FIX: begin
                    // Re-read after a lost grant: the CPU may have rewritten the word.
                    if (!grant) ce_count <= ce_count - CNT_W'(ce_bump);
                    state <= grant ? NEXT : READ;
                end
                NEXT: if (arr_addr == ADDR_W'(DEPTH - 1)) begin
                    req   <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    arr_addr <= arr_addr + ADDR_W'(1);
                    state    <= READ;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_edc_scrubber.sv
// tb_edc_scrubber: vector-table and scoreboard bench for the cache array scrubber.
module tb_edc_scrubber;
    logic clk = 0, rst = 1, start = 0, grant = 1;
    logic req, arr_we, busy, done, ue_flag;
    logic [8:0] arr_addr, ue_addr;
    logic [31:0] arr_data, arr_wdata;
    logic [6:0] arr_parity, arr_wparity;
    logic [15:0] ce_count, ue_count;
    logic [31:0] mem_d [512];
    logic [6:0] mem_p [512];

    edc_scrubber dut (
        .clk(clk), .rst(rst), .start(start), .grant(grant), .req(req),
        .arr_addr(arr_addr), .arr_data(arr_data), .arr_parity(arr_parity),
        .arr_we(arr_we), .arr_wdata(arr_wdata), .arr_wparity(arr_wparity),
        .busy(busy), .done(done), .ce_count(ce_count), .ue_count(ue_count),
        .ue_flag(ue_flag), .ue_addr(ue_addr)
    );

    always #5 clk = ~clk;
    assign arr_data   = mem_d[arr_addr];
    assign arr_parity = mem_p[arr_addr];

    always @(posedge clk) begin
        if (arr_we) begin
            mem_d[arr_addr] <= arr_wdata;
            mem_p[arr_addr] <= arr_wparity;
        end
    end

    typedef struct {logic [8:0] a; logic [31:0] d; logic [6:0] p;} wr_t;
    typedef struct {
        int a0; logic [31:0] d0; logic [6:0] p0;
        int a1; logic [31:0] d1; logic [6:0] p1;
        int drop; int mid; bit wr; logic [31:0] wd; logic [6:0] wp;
        int ce; int ue; bit flag; int uea;
    } vec_t;

    wr_t exp_q[$];
    wr_t e_m;
    vec_t vecs[8];
    int nchk = 0, npass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (arr_we) begin
            if (exp_q.size() == 0) begin
                nchk++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h parity 0x%0h, want no write",
                         arr_addr, arr_wdata, arr_wparity);
            end else begin
                e_m = exp_q.pop_front();
                chk("wr_addr", arr_addr, e_m.a);
                chk("wr_data", arr_wdata, e_m.d);
                chk("wr_parity", arr_wparity, e_m.p);
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) begin
            mem_d[i] <= '0;
            mem_p[i] <= '0;
        end
    endtask

    task automatic run_pass(input int drop, input int mid, output int cyc);
        int seen = 0;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        cyc = 1;
        chk("busy_req", {busy, req}, 2'b11);
        while (!done && cyc < 4000) begin
            seen += (int'(arr_addr) == drop) ? 1 : 0;
            grant = !(int'(arr_addr) == drop && seen == 3);
            start = (cyc == mid);
            if (int'(arr_addr) == drop && seen == 4) chk("ce_undo", ce_count, 0);
            if (!grant) begin
                @(negedge clk);
                chk("we_gated", arr_we, 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        grant = 1;
        start = 0;
        chk("done_seen", done, 1);
        @(posedge clk); #1;
        chk("done_pulse", {done, busy, req}, 0);
    endtask

    task automatic apply(input int n, input vec_t v);
        int cyc;
        clear_mem();
        if (v.a0 >= 0) begin
            mem_d[v.a0] <= v.d0;
            mem_p[v.a0] <= v.p0;
        end
        if (v.a1 >= 0) begin
            mem_d[v.a1] <= v.d1;
            mem_p[v.a1] <= v.p1;
        end
        #1;
        if (v.wr) exp_q.push_back('{9'(v.a0), v.wd, v.wp});
        run_pass(v.drop, v.mid, cyc);
        if (v.drop < 0) chk($sformatf("v%0d_cycles", n), cyc, 1537 + int'(v.wr));
        chk($sformatf("v%0d_ce", n), ce_count, v.ce);
        chk($sformatf("v%0d_ue", n), ue_count, v.ue);
        chk($sformatf("v%0d_flag", n), ue_flag, v.flag);
        chk($sformatf("v%0d_ue_addr", n), ue_addr, v.uea);
        chk($sformatf("v%0d_pending", n), exp_q.size(), 0);
        if (v.a0 >= 0)
            chk($sformatf("v%0d_mem0", n), {mem_d[v.a0], mem_p[v.a0]},
                v.wr ? {v.wd, v.wp} : {v.d0, v.p0});
        if (v.a1 >= 0)
            chk($sformatf("v%0d_mem1", n), {mem_d[v.a1], mem_p[v.a1]}, {v.d1, v.p1});
    endtask

    initial begin
        int cyc;
        //          a0   d0            p0     a1   d1            p1     drop mid  wr wd            wp     ce ue flag uea
        vecs[0] = '{-1,  32'h0,        7'h00, -1,  32'h0,        7'h00, -1,  300, 0, 32'h0,        7'h00, 0, 0, 0, 0};
        vecs[1] = '{5,   32'h1,        7'h00, -1,  32'h0,        7'h00, -1,  -1,  1, 32'h0,        7'h00, 1, 0, 0, 0};
        vecs[2] = '{7,   32'h0,        7'h01, -1,  32'h0,        7'h00, -1,  -1,  1, 32'h0,        7'h00, 1, 0, 0, 0};
        vecs[3] = '{9,   32'h3,        7'h00, 20,  32'h3,        7'h00, -1,  300, 0, 32'h0,        7'h00, 0, 2, 1, 9};
        vecs[4] = '{5,   32'h1,        7'h00, -1,  32'h0,        7'h00, 5,   -1,  1, 32'h0,        7'h00, 1, 0, 0, 0};
        vecs[5] = '{30,  32'h0,        7'h43, -1,  32'h0,        7'h00, -1,  -1,  1, 32'h1,        7'h43, 1, 0, 0, 0};
        vecs[6] = '{511, 32'h0,        7'h40, -1,  32'h0,        7'h00, -1,  -1,  1, 32'h0,        7'h00, 1, 0, 0, 0};
        vecs[7] = '{0,   32'h0,        7'h7F, 3,   32'h80000000, 7'h26, -1,  -1,  0, 32'h0,        7'h00, 0, 1, 1, 0};
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", {req, busy, done, arr_we, ue_flag}, 0);
        chk("rst_addr", {arr_addr, ue_addr}, 0);
        chk("rst_cnt", {ce_count, ue_count}, 0);
        chk("rst_wr", {arr_wdata, arr_wparity}, 0);
        rst = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) apply(i, vecs[i]);

        // Reset in the middle of a pass, then a clean rescan.
        clear_mem();
        mem_d[5] <= 32'h1;
        mem_d[9] <= 32'h3;
        #1;
        exp_q.push_back('{9'd5, 32'h0, 7'h00});
        start = 1;
        @(posedge clk); #1;
        start = 0;
        cyc = 0;
        while (arr_addr != 9'd100 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_100", arr_addr, 100);
        rst = 1;
        #1;
        chk("mid_rst_ctl", {busy, req, arr_we, done, ue_flag}, 0);
        chk("mid_rst_addr", {arr_addr, ue_addr}, 0);
        chk("mid_rst_cnt", {ce_count, ue_count}, 0);
        chk("mid_rst_mem5", {mem_d[5], mem_p[5]}, 0);
        chk("mid_rst_pending", exp_q.size(), 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        run_pass(-1, -1, cyc);
        chk("rescan_cycles", cyc, 1537);
        chk("rescan_ce", ce_count, 0);
        chk("rescan_ue", ue_count, 1);
        chk("rescan_flag", ue_flag, 1);
        chk("rescan_ue_addr", ue_addr, 9);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
